load_store_unit: RTL and testbench

// - Sits between the single-cycle core's data-memory port and a word-wide data RAM with a req/gnt/rvalid handshake.
// - Turns one core request (lb/lbu/lh/lhu/lw/sb/sh/sw) into one memory transaction.
// - Generates byte enables and lane-replicated store data; extracts and sign/zero-extends load data.
// - Stalls the core until the access completes; flags illegal, misaligned and timed-out accesses.

---
 rtl/load_store_unit_if.sv | 39 +++
 rtl/load_store_unit.sv | 163 ++++++++++++++++
 tb/tb_load_store_unit.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: core-side request/response and RAM-side req/gnt/rvalid
// signals of the load/store unit, bundled as one bus.
//   slave  : the load/store unit itself
//   master : the environment (core driving requests, RAM answering them)
interface load_store_unit_if;
  // core side
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        err;
  // RAM side
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output stall, rsp_valid, rsp_rdata, err,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  stall, rsp_valid, rsp_rdata, err,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: turns one RV32I load/store from a single-cycle core into one
// req/gnt/rvalid transaction on a word-wide RAM. Builds byte enables and
// lane-replicated store data, extracts and extends load data, stalls the core
// until completion and flags illegal funct3 and timed-out accesses.
// Optional feature macro: MISALIGN_TRAP_EN -- when defined, misaligned
// halfword/word accesses are rejected with err instead of being silently
// aligned down to the access width.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 64  // REQ+WAIT cycles before abort, 2..255
) (
  input  logic             clk,
  input  logic             reset,      // synchronous, active low
  load_store_unit_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  // last timer value still allowed to wait; reaching it aborts the access
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_timer;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic [2:0]  r_funct3;
  logic        r_we, r_err;

  logic        w_illegal, w_misalign, w_reject;
  logic        w_tmo_hit, w_ld_done, w_timeout;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_ext;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // loads reject 011/110/111, stores reject everything from 011 up
  assign w_illegal = bus.req_we ? (bus.req_funct3[2] | (bus.req_funct3[1:0] == 2'b11))
                                : ((bus.req_funct3[1:0] == 2'b11) | (bus.req_funct3 == 3'b110));

`ifdef MISALIGN_TRAP_EN
  assign w_misalign = ((bus.req_funct3[1:0] == 2'b01) & bus.req_addr[0]) |
                      ((bus.req_funct3[1:0] == 2'b10) & (bus.req_addr[1:0] != 2'b00));
`else
  // low address bits below the access width are simply dropped
  assign w_misalign = 1'b0;
`endif

  assign w_reject  = w_illegal | w_misalign;
  assign w_tmo_hit = (r_timer >= TMO_LAST);

  // byte enables and replicated store data; funct3[1:0] is the access size
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = r_wdata;
    case (r_funct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << r_addr[1:0];
        w_wdata = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << {r_addr[1], 1'b0};
        w_wdata = {2{r_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // pick the addressed lane from the raw RAM word and extend it
  always_comb begin
    w_byte = bus.mem_rdata[7:0];
    case (r_addr[1:0])
      2'd1:    w_byte = bus.mem_rdata[15:8];
      2'd2:    w_byte = bus.mem_rdata[23:16];
      2'd3:    w_byte = bus.mem_rdata[31:24];
      default: ;
    endcase
    w_half = r_addr[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    w_ext  = bus.mem_rdata;
    case (r_funct3)
      3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_ext = {24'h0, w_byte};
      3'b001:  w_ext = {{16{w_half[15]}}, w_half};
      3'b101:  w_ext = {16'h0, w_half};
      default: ;
    endcase
  end

  // next state; gnt/rvalid only matter in REQ/WAIT so stale responses drop
  always_comb begin
    w_state_nxt = r_state;
    w_ld_done   = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: if (bus.req_valid) w_state_nxt = w_reject ? S_DONE : S_REQ;
      S_REQ: begin
        if (bus.mem_gnt) begin
          if (r_we) begin
            w_state_nxt = S_DONE;
          end else if (bus.mem_rvalid) begin
            w_state_nxt = S_DONE;
            w_ld_done   = 1'b1;
          end else begin
            w_state_nxt = S_WAIT;
          end
        end else if (w_tmo_hit) begin
          w_state_nxt = S_DONE;
          w_timeout   = 1'b1;
        end
      end
      S_WAIT: begin
        if (bus.mem_rvalid) begin
          w_state_nxt = S_DONE;
          w_ld_done   = 1'b1;
        end else if (w_tmo_hit) begin
          w_state_nxt = S_DONE;
          w_timeout   = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // request capture, response data/error and the REQ+WAIT timer
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_timer  <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_funct3 <= '0;
      r_we     <= 1'b0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      if (r_state == S_IDLE)                             r_timer <= '0;
      else if ((r_state == S_REQ) || (r_state == S_WAIT)) r_timer <= r_timer + 8'd1;

      if ((r_state == S_IDLE) && bus.req_valid) begin
        r_addr   <= bus.req_addr;
        r_wdata  <= bus.req_wdata;
        r_funct3 <= bus.req_funct3;
        r_we     <= bus.req_we;
        r_rdata  <= '0;
        r_err    <= w_reject;
      end
      if (w_ld_done) r_rdata <= w_ext;
      if (w_timeout) r_err   <= 1'b1;
    end
  end

  // outputs are decoded from state so everything reads 0 right after reset
  assign bus.stall     = ((r_state == S_IDLE) & bus.req_valid) | (r_state == S_REQ) | (r_state == S_WAIT);
  assign bus.rsp_valid = (r_state == S_DONE);
  assign bus.rsp_rdata = (r_state == S_DONE) ? r_rdata : '0;
  assign bus.err       = (r_state == S_DONE) & r_err;
  assign bus.mem_req   = (r_state == S_REQ);
  assign bus.mem_we    = (r_state == S_REQ) & r_we;
  assign bus.mem_addr  = (r_state == S_REQ) ? {r_addr[31:2], 2'b00} : '0;
  assign bus.mem_be    = (r_state == S_REQ) ? w_be : '0;
  assign bus.mem_wdata = ((r_state == S_REQ) && r_we) ? w_wdata : '0;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: scoreboard bench. Stimulus drives core ops and pushes the
// expected response (data, err, stall cycles) computed from a byte-array model;
// a monitor pops and compares on each rsp_valid; a RAM process answers
// mem_req with per-op gnt/rvalid delays chosen by the stimulus.
`timescale 1ns/1ps
module tb_load_store_unit;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  load_store_unit_if bus();

  load_store_unit #(.TIMEOUT(TMO)) u_dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          stalls;
  } exp_t;

  exp_t        sb_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  refmem [0:255];
  logic [31:0] ram    [0:63];
  int          cur_g = 0, cur_r = 0;
  bit          gnt_block = 1'b0;
  logic [31:0] exp_waddr = '0;
  int          exp_txn = 0, n_txn = 0;
  int          stray_req = 0, stray_done = 0;
  int          req_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // reference: byte-addressed memory, legality by funct3, plain arithmetic extension
  function automatic void model(input bit we, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, output logic [31:0] rd,
                                output bit err, output bit txn);
    int size, base, aa;
    logic [31:0] v;
    bit legal;
    legal = we ? (f3 <= 3'd2) : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    rd = '0; err = 1'b0; txn = 1'b0;
    if (!legal) begin err = 1'b1; return; end
    size = 1 << f3[1:0];
    aa   = int'(a[7:0]);
`ifdef MISALIGN_TRAP_EN
    if (aa % size != 0) begin err = 1'b1; return; end
`endif
    base = aa - (aa % size);
    txn  = 1'b1;
    if (we) begin
      for (int i = 0; i < size; i++) refmem[base + i] = wd[8*i +: 8];
    end else begin
      v = '0;
      for (int i = 0; i < size; i++) v = v | (32'(refmem[base + i]) << (8 * i));
      if (!f3[2] && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8 * size));
      rd = v;
    end
  endfunction

  // present one op; expected response comes from the model unless overridden
  task automatic start_op(input bit we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int g, input int r, input bit push,
                          input bit ovr, input logic [31:0] ovr_rd, input bit ovr_err, input int ovr_st);
    exp_t e;
    logic [31:0] rd;
    bit err, txn;
    model(we, f3, a, wd, rd, err, txn);
    e.rdata  = rd;
    e.err    = err;
    e.stalls = !txn ? 1 : (we ? 2 + g : 2 + g + r);
    if (ovr) begin
      e.rdata = ovr_rd;
      e.err   = ovr_err;
      if (ovr_st >= 0) e.stalls = ovr_st;
    end
    if (txn && !gnt_block) exp_txn++;
    cur_g     = g;
    cur_r     = r;
    exp_waddr = {a[31:2], 2'b00};
    if (push) sb_q.push_back(e);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
  endtask

  // hold the op until stall drops (DONE), then withdraw it
  task automatic finish_op();
    bit done;
    done = 1'b0;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      if (!bus.stall) done = 1'b1;
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL stall_release: stall still 1 after 40 cycles, required 0");
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  // RAM: grants after cur_g waiting cycles, returns load data cur_r cycles after gnt
  initial begin : ram_model
    int gcnt, rcnt;
    bit rpend;
    logic [5:0] ridx;
    gcnt = 0; rcnt = 0; rpend = 1'b0; ridx = '0;
    for (int i = 0; i < 64; i++) ram[i] = '0;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      bus.mem_gnt    = 1'b0;
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = $urandom;
      if (stray_req != stray_done) begin
        bus.mem_rvalid = 1'b1;
        stray_done++;
      end else if (rpend) begin
        if (rcnt <= 1) begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata  = ram[ridx];
          rpend = 1'b0;
        end else rcnt--;
      end else if (bus.mem_req === 1'b1 && !gnt_block) begin
        if (gcnt < cur_g) gcnt++;
        else begin
          gcnt = 0;
          bus.mem_gnt = 1'b1;
          n_txn++;
          check("mem_addr", bus.mem_addr, exp_waddr);
          ridx = bus.mem_addr[7:2];
          if (bus.mem_we) begin
            for (int b = 0; b < 4; b++)
              if (bus.mem_be[b]) ram[ridx][8*b +: 8] = bus.mem_wdata[8*b +: 8];
          end else if (cur_r == 0) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = ram[ridx];
          end else begin
            rpend = 1'b1;
            rcnt  = cur_r;
          end
        end
      end
    end
  end

  // monitor: pops the scoreboard on rsp_valid, checks idle outputs and request stability
  initial begin : monitor
    int stall_cnt;
    bit prev_req;
    logic [31:0] prev_addr;
    exp_t e;
    stall_cnt = 0; prev_req = 1'b0; prev_addr = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        stall_cnt = 0;
        prev_req  = 1'b0;
      end else begin
        if (bus.mem_req) req_cyc++;
        if (prev_req && bus.mem_req) check("mem_addr_stable", bus.mem_addr, prev_addr);
        prev_req  = bus.mem_req && !bus.mem_gnt;
        prev_addr = bus.mem_addr;
        if (bus.stall) stall_cnt++;
        if (bus.rsp_valid) begin
          if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_rsp: rsp_valid=1 rdata 0x%08h err %0b, required no response",
                     bus.rsp_rdata, bus.err);
          end else begin
            e = sb_q.pop_front();
            check("rsp_rdata", bus.rsp_rdata, e.rdata);
            check("rsp_err", {31'b0, bus.err}, {31'b0, e.err});
            check("stall_cycles", stall_cnt, e.stalls);
          end
          stall_cnt = 0;
        end else begin
          check("idle_rsp_zero", bus.rsp_rdata | {31'b0, bus.err}, 32'h0);
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [31:0] a, wd;
    logic [2:0]  f3;
    bit          we;
    int          g, r, gap, cyc0;
    logic [2:0]  ldf3 [5];
    logic [2:0]  tf3  [5];
    logic [31:0] taddr[5];
    logic [31:0] tex  [5];
    ldf3[0] = 3'd0; ldf3[1] = 3'd1; ldf3[2] = 3'd2; ldf3[3] = 3'd4; ldf3[4] = 3'd5;
    tf3[0] = 3'b000; taddr[0] = 32'h102; tex[0] = 32'hFFFF_FFFF;
    tf3[1] = 3'b100; taddr[1] = 32'h102; tex[1] = 32'h0000_00FF;
    tf3[2] = 3'b001; taddr[2] = 32'h102; tex[2] = 32'hFFFF_80FF;
    tf3[3] = 3'b101; taddr[3] = 32'h102; tex[3] = 32'h0000_80FF;
    tf3[4] = 3'b010; taddr[4] = 32'h100; tex[4] = 32'h80FF_7F01;
    for (int i = 0; i < 256; i++) refmem[i] = '0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = '0;
    bus.req_addr = '0; bus.req_wdata = '0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ctl", {23'b0, bus.stall, bus.rsp_valid, bus.err, bus.mem_req, bus.mem_we, bus.mem_be}, 32'h0);
    check("rst_rdata", bus.rsp_rdata, 32'h0);
    check("rst_maddr", bus.mem_addr, 32'h0);
    check("rst_mwdata", bus.mem_wdata, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // sb 0x103: replicated byte on lane 3, immediate grant
    start_op(1'b1, 3'b000, 32'h103, 32'h0000_00AB, 0, 0, 1'b1, 1'b0, '0, 1'b0, -1);
    @(negedge clk);
    @(negedge clk);
    check("sb_mem_addr", bus.mem_addr, 32'h100);
    check("sb_mem_be", {28'b0, bus.mem_be}, 32'h8);
    check("sb_mem_wdata", bus.mem_wdata, 32'hABAB_ABAB);
    check("sb_mem_we", {31'b0, bus.mem_we}, 32'h1);
    finish_op();

    // word at 0x100, then every load flavour against known constants
    start_op(1'b1, 3'b010, 32'h100, 32'h80FF_7F01, 1, 0, 1'b1, 1'b0, '0, 1'b0, -1);
    finish_op();
    for (int t = 0; t < 5; t++) begin
      start_op(1'b0, tf3[t], taddr[t], '0, 0, t % 3, 1'b1, 1'b1, tex[t], 1'b0, -1);
      finish_op();
    end

    // slow RAM: 3 REQ cycles, rvalid 2 cycles after gnt
    cyc0 = req_cyc;
    start_op(1'b0, 3'b010, 32'h100, '0, 2, 2, 1'b1, 1'b1, 32'h80FF_7F01, 1'b0, 6);
    finish_op();
    check("slow_req_cycles", req_cyc - cyc0, 32'd3);

    // lw at odd address (trapped or aligned down depending on build)
    start_op(1'b0, 3'b010, 32'h101, '0, 0, 1, 1'b1, 1'b0, '0, 1'b0, -1);
    finish_op();

    // illegal funct3 for a load and a store
    start_op(1'b0, 3'b011, 32'h10, '0, 0, 0, 1'b1, 1'b0, '0, 1'b0, -1);
    finish_op();
    start_op(1'b1, 3'b100, 32'h14, 32'h1234_5678, 0, 0, 1'b1, 1'b0, '0, 1'b0, -1);
    finish_op();

    // timeout with gnt tied low, then a stray rvalid that must be ignored
    gnt_block = 1'b1;
    cyc0 = req_cyc;
    start_op(1'b0, 3'b010, 32'h20, '0, 0, 0, 1'b1, 1'b1, 32'h0, 1'b1, TMO + 1);
    finish_op();
    check("tmo_req_cycles", req_cyc - cyc0, TMO);
    stray_req++;
    repeat (3) @(posedge clk);
    #1;
    gnt_block = 1'b0;

    // reset while in WAIT; the late rvalid after release must not respond
    start_op(1'b0, 3'b010, 32'h40, '0, 0, 5, 1'b0, 1'b0, '0, 1'b0, -1);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("wrst_ctl", {23'b0, bus.stall, bus.rsp_valid, bus.err, bus.mem_req, bus.mem_we, bus.mem_be}, 32'h0);
    check("wrst_data", bus.rsp_rdata | bus.mem_addr | bus.mem_wdata, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    // randomized traffic
    for (int k = 0; k < 200; k++) begin
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) f3 = 3'($urandom_range(0, 7));
      else if (we)                   f3 = 3'($urandom_range(0, 2));
      else                           f3 = ldf3[$urandom_range(0, 4)];
      a   = 32'($urandom_range(0, 255));
      wd  = $urandom;
      g   = $urandom_range(0, 3);
      r   = $urandom_range(0, 2);
      start_op(we, f3, a, wd, g, r, 1'b1, 1'b0, '0, 1'b0, -1);
      finish_op();
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(posedge clk); #1;
      end
    end

    for (int n = 0; n < 20 && sb_q.size() != 0; n++) @(negedge clk);
    check("queue_drained", sb_q.size(), 32'h0);
    check("txn_count", n_txn, exp_txn);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
